uart_tx_ctrl: RTL

Frame-sequencing controller for the UART transmitter. Accepts a byte request, then drives the serializer enable, the output-mux select and the busy flag, slot by slot, through start, data, optional parity and stop bits. It sits beside the transmitter's parity calculator, serializer and output mux, in the TX clock domain, where one clock cycle equals one bit time.

---
 rtl/uart_tx_pkg.sv | 20 ++
 rtl/uart_tx_ctrl.sv | 91 +++++++++
 2 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART TX definitions: frame FSM states, line-mux select codes and
// the default frame width used by the controller, output mux and serializer.
package uart_tx_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: steps start, data, optional parity and stop slots,
// one bit time per clock, and cross-checks the serializer's last-bit flag.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DATA_VALID,
  input  logic       PAR_EN,
  input  logic       SER_DONE,
  output logic       SER_EN,
  output logic [1:0] MUX_SEL,
  output logic       BUSY,
  output logic       FRAME_DONE,
  output logic       SEQ_ERR
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             par_en_q, par_en_d;
  logic             seq_err_q, seq_err_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      par_en_q  <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      par_en_q  <= par_en_d;
      seq_err_q <= seq_err_d;
    end
  end

  // Outputs depend on state_q only, so the line source never glitches on inputs.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    par_en_d   = par_en_q;
    seq_err_d  = seq_err_q;
    MUX_SEL    = MUX_STOP;
    BUSY       = 1'b0;
    SER_EN     = 1'b0;
    FRAME_DONE = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (DATA_VALID) begin
          state_d   = START;
          par_en_d  = PAR_EN;
          bit_cnt_d = '0;
        end
      end
      START: begin
        MUX_SEL = MUX_START;
        BUSY    = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        MUX_SEL   = MUX_DATA;
        BUSY      = 1'b1;
        SER_EN    = 1'b1;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        // Serializer must flag its last bit exactly in our last data slot.
        if (SER_DONE != (bit_cnt_q == LAST_BIT)) seq_err_d = 1'b1;
        if (bit_cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        MUX_SEL = MUX_PAR;
        BUSY    = 1'b1;
        state_d = STOP;
      end
      STOP: begin
        MUX_SEL    = MUX_STOP;
        BUSY       = 1'b1;
        FRAME_DONE = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign SEQ_ERR = seq_err_q;

endmodule
